// File: rtl/store_size_unit.sv
// Register-to-memory store unit: SW direct write, SH/SB via read-modify-write of the aligned word.
// Define STORE_SIZE_BYTE_EN_EN to add mem_be and write sub-words directly with lane enables.
module store_size_unit #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  store_size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata_reg,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
`ifdef STORE_SIZE_BYTE_EN_EN
  output logic [3:0]  mem_be,
`endif
  output logic        busy,
  output logic        done,
  output logic        misaligned
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, ERR} state_t;

  localparam logic [1:0] SZ_W = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_B = 2'b10;
  localparam logic [2:0] CNT_INIT = 3'(MEM_LATENCY - 1);

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic [15:0] wdata_q;
  logic [31:0] mem_wdata_q;
  logic        illegal;

  always_comb begin
    illegal = (store_size == 2'b11) ||
              ((store_size == SZ_H) && addr[0]) ||
              ((store_size == SZ_W) && (addr[1:0] != 2'b00));
  end

`ifdef STORE_SIZE_BYTE_EN_EN
  logic [31:0] repl_w;
  logic [3:0]  be_w;

  always_comb begin
    case (store_size)
      SZ_B:    repl_w = {4{wdata_reg[7:0]}};
      SZ_H:    repl_w = {2{wdata_reg[15:0]}};
      default: repl_w = wdata_reg;
    endcase
  end

  always_comb begin
    case (size_q)
      SZ_B:    be_w = 4'b0001 << addr_q[1:0];
      SZ_H:    be_w = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be_w = 4'b1111;
    endcase
  end

  assign mem_be = (state_q == WRITE) ? be_w : 4'b0000;
`else
  logic [31:0] merged;

  // Replace only the addressed lane of the word just read back.
  always_comb begin
    merged = mem_rdata;
    if (size_q == SZ_B)
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else if (addr_q[1])
      merged[31:16] = wdata_q;
    else
      merged[15:0] = wdata_q;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      addr_q      <= 32'd0;
      size_q      <= 2'b00;
      wdata_q     <= 16'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q  <= addr;
            size_q  <= store_size;
            wdata_q <= wdata_reg[15:0];
            if (illegal) begin
              state_q <= ERR;
            end else begin
`ifdef STORE_SIZE_BYTE_EN_EN
              mem_wdata_q <= repl_w;
              state_q     <= WRITE;
`else
              if (store_size == SZ_W) begin
                mem_wdata_q <= wdata_reg;
                state_q     <= WRITE;
              end else begin
                cnt_q   <= CNT_INIT;
                state_q <= READ;
              end
`endif
            end
          end
        end
        READ: begin
          if (cnt_q == 3'd0) begin
`ifndef STORE_SIZE_BYTE_EN_EN
            mem_wdata_q <= merged;
`endif
            state_q <= WRITE;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        WRITE:   state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Every output decodes registered state, so an async reset drops mem_wr at once.
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_wdata  = mem_wdata_q;
  assign mem_wr     = (state_q == WRITE);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == WRITE) || (state_q == ERR);
  assign misaligned = (state_q == ERR);

endmodule

// File: tb/tb_store_size_unit.sv
// Scoreboard bench for store_size_unit: directed stores push expectations, a negedge monitor checks done cycles.
// Also exercises STORE_SIZE_BYTE_EN_EN when that macro is defined for the build.
module tb_store_size_unit;

  localparam int LAT = 3;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  store_size;
  logic [31:0] addr;
  logic [31:0] wdata_reg;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
`ifdef STORE_SIZE_BYTE_EN_EN
  logic [3:0]  mem_be;
`endif
  logic        busy;
  logic        done;
  logic        misaligned;

  store_size_unit #(.MEM_LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .store_size (store_size),
    .addr       (addr),
    .wdata_reg  (wdata_reg),
    .mem_rdata  (mem_rdata),
    .mem_addr   (mem_addr),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
`ifdef STORE_SIZE_BYTE_EN_EN
    .mem_be     (mem_be),
`endif
    .busy       (busy),
    .done       (done),
    .misaligned (misaligned)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic        mis;
    logic [3:0]  be;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   rd_valid_cyc = -1;
  logic [31:0] rdata_cur = 32'd0;

  // Memory read data is only valid in the single cycle the latency says it is.
  assign mem_rdata = (cyc == rd_valid_cyc) ? rdata_cur : 32'hBAD0_BAD0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_wr", {31'd0, mem_wr}, {31'd0, e.wr});
          chk("misaligned", {31'd0, misaligned}, {31'd0, e.mis});
          chk("busy_at_done", {31'd0, busy}, 32'd1);
          if (e.wr) chk("mem_wdata", mem_wdata, e.wdata);
`ifdef STORE_SIZE_BYTE_EN_EN
          chk("mem_be", {28'd0, mem_be}, {28'd0, e.be});
`endif
          $display("txn addr=%h wr=%0d wdata=%h mis=%0d cyc=%0d", mem_addr, mem_wr, mem_wdata, misaligned, cyc);
        end
      end else begin
        chk("wr_without_done", {31'd0, mem_wr}, 32'd0);
        chk("mis_without_done", {31'd0, misaligned}, 32'd0);
`ifdef STORE_SIZE_BYTE_EN_EN
        chk("be_outside_write", {28'd0, mem_be}, 32'd0);
`endif
      end
    end
  end

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
    @(negedge clk);
    chk("busy_after", {31'd0, busy}, 32'd0);
  endtask

  // exp_rmw: merged word for the read-modify-write build; exp_rep: replicated word with byte enables.
  task automatic issue(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input logic err, input logic [31:0] exp_rmw,
                       input logic [31:0] exp_rep, input logic [3:0] be, input logic repulse);
    exp_t e;
    int   n;
    @(negedge clk);
    n = cyc;
    e.addr  = {a[31:2], 2'b00};
    e.wr    = !err;
    e.mis   = err;
`ifdef STORE_SIZE_BYTE_EN_EN
    e.wdata = exp_rep;
    e.be    = err ? 4'b0000 : be;
    e.cyc   = n + 1;
`else
    e.wdata = exp_rmw;
    e.be    = be;
    e.cyc   = (err || sz == 2'b00) ? n + 1 : n + LAT + 1;
`endif
    sb.push_back(e);
    rdata_cur    = rd;
    rd_valid_cyc = n + LAT;
    store_size   = sz;
    addr         = a;
    wdata_reg    = wd;
    start        = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    store_size = 2'b00;
    addr       = 32'h0000_0080;
    wdata_reg  = 32'h5A5A_5A5A;
    if (repulse) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (cyc < n + LAT + 1) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
    end
    drain();
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    store_size = 2'b00;
    addr       = 32'd0;
    wdata_reg  = 32'd0;
    #2;
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_mis", {31'd0, misaligned}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Asynchronous reset in the WRITE cycle must kill the strobe immediately.
    @(negedge clk);
    store_size = 2'b00;
    addr       = 32'h0000_0030;
    wdata_reg  = 32'h0123_4567;
    start      = 1'b1;
    @(posedge clk);
    #1;
    chk("pre_rst_wr", {31'd0, mem_wr}, 32'd1);
    start = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("async_wr", {31'd0, mem_wr}, 32'd0);
    chk("async_done", {31'd0, done}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_addr", mem_addr, 32'd0);
    chk("async_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    issue(2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111, 1'b0);
    issue(2'b10, 32'h0000_0023, 32'h0000_00AB, 32'h1122_3344, 1'b0, 32'hAB22_3344, 32'hABAB_ABAB, 4'b1000, 1'b0);
    issue(2'b01, 32'h0000_0042, 32'h0000_CAFE, 32'h1122_3344, 1'b0, 32'hCAFE_3344, 32'hCAFE_CAFE, 4'b1100, 1'b0);
    issue(2'b01, 32'h0000_0040, 32'h1234_BEEF, 32'h1122_3344, 1'b0, 32'h1122_BEEF, 32'hBEEF_BEEF, 4'b0011, 1'b0);
    issue(2'b10, 32'h0000_0000, 32'h0000_0055, 32'hAABB_CCDD, 1'b0, 32'hAABB_CC55, 32'h5555_5555, 4'b0001, 1'b0);
    issue(2'b10, 32'h0000_0001, 32'h0000_0099, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_99FF, 32'h9999_9999, 4'b0010, 1'b0);
    issue(2'b10, 32'hFFFF_FFFF, 32'h0000_0077, 32'h0000_0000, 1'b0, 32'h7700_0000, 32'h7777_7777, 4'b1000, 1'b0);
    issue(2'b01, 32'h0000_0041, 32'h0000_1111, 32'h0,         1'b1, 32'h0,         32'h0,         4'b0000, 1'b0);
    issue(2'b00, 32'h0000_0006, 32'h2222_2222, 32'h0,         1'b1, 32'h0,         32'h0,         4'b0000, 1'b0);
    issue(2'b11, 32'h0000_0000, 32'h3333_3333, 32'h0,         1'b1, 32'h0,         32'h0,         4'b0000, 1'b0);
    issue(2'b10, 32'h0000_0062, 32'h0000_00C3, 32'h0102_0304, 1'b0, 32'h01C3_0304, 32'hC3C3_C3C3, 4'b0100, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
